// File: rtl/arb_req_tracker_pkg.sv
// arb_pkg: shared defaults and types for the arbiter family.
//   ARB_N        - default number of clients
//   ARB_CNT_W    - default per-client pending-count width
//   ARB_STARVE_W - default per-client wait-counter width
//   gnt_kind_e   - classification of an incoming grant vector
package arb_pkg;

  localparam int ARB_N        = 32;
  localparam int ARB_CNT_W    = 2;
  localparam int ARB_STARVE_W = 8;

  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_ONEHOT = 2'd1,
    GNT_MULTI  = 2'd2
  } gnt_kind_e;

endpackage

// File: rtl/arb_req_tracker_if.sv
// arb_req_tracker_if: request/grant bundle between clients, the tracker and
// the arbiter.
//   push_i   - per-client new-request event
//   gnt_i    - grant vector from the arbiter (one-hot or zero expected)
//   req_o    - per-client request (pending count nonzero)
//   full_o   - per-client pending count at maximum
//   served_o - registered pulse of the accepted grant
//   drop_o   - registered pulse of a rejected push
//   starve_o - per-client wait counter saturated
//   err_o    - sticky protocol-error flag
// master: the side that drives push/grant; slave: the tracker.
interface arb_req_tracker_if
  import arb_pkg::*;
#(
  parameter int N = ARB_N
);

  logic [N-1:0] push_i;
  logic [N-1:0] gnt_i;
  logic [N-1:0] req_o;
  logic [N-1:0] full_o;
  logic [N-1:0] served_o;
  logic [N-1:0] drop_o;
  logic [N-1:0] starve_o;
  logic         err_o;

  modport master (
    output push_i, gnt_i,
    input  req_o, full_o, served_o, drop_o, starve_o, err_o
  );

  modport slave (
    input  push_i, gnt_i,
    output req_o, full_o, served_o, drop_o, starve_o, err_o
  );

endinterface

// File: rtl/arb_client_slot.sv
// arb_client_slot: state for one client of the request tracker.
//   clk, reset - clock, synchronous active-low reset
//   push_i     - new request this cycle
//   vg_i       - this client's bit of the validated grant
//   req_o      - pending count nonzero
//   full_o     - pending count at maximum
//   served_o   - registered vg_i
//   drop_o     - registered "push rejected because full"
//   starve_o   - wait counter saturated
module arb_client_slot
  import arb_pkg::*;
#(
  parameter int CNT_W    = ARB_CNT_W,
  parameter int STARVE_W = ARB_STARVE_W
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic vg_i,
  output logic req_o,
  output logic full_o,
  output logic served_o,
  output logic drop_o,
  output logic starve_o
);

  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
  localparam logic [STARVE_W-1:0] WAIT_MAX = '1;

  logic [CNT_W-1:0]    count_q, count_d;
  logic [STARVE_W-1:0] wait_q, wait_d;
  logic                served_q, served_d;
  logic                drop_q, drop_d;

  assign req_o    = (count_q != '0);
  assign full_o   = (count_q == CNT_MAX);
  assign starve_o = (wait_q == WAIT_MAX);
  assign served_o = served_q;
  assign drop_o   = drop_q;

  always_comb begin
    count_d  = count_q;
    wait_d   = wait_q;
    drop_d   = 1'b0;
    served_d = vg_i;

    // A push and a grant in the same cycle cancel, so a full client can
    // still accept a push while it is being served.
    if (push_i && !vg_i) begin
      if (full_o) drop_d = 1'b1;
      else        count_d = count_q + CNT_W'(1);
    end else if (vg_i && !push_i && req_o) begin
      count_d = count_q - CNT_W'(1);
    end

    if (!req_o || vg_i)  wait_d = '0;
    else if (!starve_o)  wait_d = wait_q + STARVE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q  <= '0;
      wait_q   <= '0;
      served_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      wait_q   <= wait_d;
      served_q <= served_d;
      drop_q   <= drop_d;
    end
  end

endmodule

// File: rtl/arb_req_tracker.sv
// arb_req_tracker: per-client pending-request bookkeeping in front of a
// single-cycle arbiter.
//   clk   - sole clock, rising edge
//   reset - synchronous active-low reset
//   bus   - arb_req_tracker_if slave: push/grant in, req/full/served/drop/
//           starve/err out
// Grant validation (one-hot check, valid grant, sticky error) lives here;
// everything per client lives in arb_client_slot.
module arb_req_tracker
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int CNT_W    = ARB_CNT_W,
  parameter int STARVE_W = ARB_STARVE_W
) (
  input  logic               clk,
  input  logic               reset,
  arb_req_tracker_if.slave   bus
);

  localparam logic [N-1:0] ONE = N'(1);

  gnt_kind_e    gnt_kind;
  logic [N-1:0] vg;
  logic [N-1:0] req_w, full_w, served_w, drop_w, starve_w;
  logic         err_q, err_d;

  always_comb begin
    gnt_kind = GNT_NONE;
    if (bus.gnt_i != '0) begin
      // Clearing the lowest set bit leaves zero only for a one-hot vector.
      if ((bus.gnt_i & (bus.gnt_i - ONE)) == '0) gnt_kind = GNT_ONEHOT;
      else                                        gnt_kind = GNT_MULTI;
    end

    vg = (gnt_kind == GNT_ONEHOT) ? (bus.gnt_i & req_w) : '0;

    err_d = err_q;
    if (gnt_kind == GNT_MULTI || (gnt_kind == GNT_ONEHOT && vg == '0))
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  for (genvar i = 0; i < N; i++) begin : g_slot
    arb_client_slot #(
      .CNT_W    (CNT_W),
      .STARVE_W (STARVE_W)
    ) u_slot (
      .clk      (clk),
      .reset    (reset),
      .push_i   (bus.push_i[i]),
      .vg_i     (vg[i]),
      .req_o    (req_w[i]),
      .full_o   (full_w[i]),
      .served_o (served_w[i]),
      .drop_o   (drop_w[i]),
      .starve_o (starve_w[i])
    );
  end

  assign bus.req_o    = req_w;
  assign bus.full_o   = full_w;
  assign bus.served_o = served_w;
  assign bus.drop_o   = drop_w;
  assign bus.starve_o = starve_w;
  assign bus.err_o    = err_q;

endmodule

// File: tb/tb_arb_req_tracker.sv
// Testbench for arb_req_tracker with N=4, CNT_W=2, STARVE_W=3.
// Directed scenarios followed by randomized push/grant traffic, all
// outputs compared every cycle against an integer-count reference model.
module tb_arb_req_tracker;

  localparam int NC       = 4;
  localparam int CMAX     = 3;
  localparam int WMAX     = 7;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  arb_req_tracker_if #(.N(NC)) bus ();

  arb_req_tracker #(
    .N        (NC),
    .CNT_W    (2),
    .STARVE_W (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: plain integer counts and wait times per client.
  int         cnt [NC];
  int         wt  [NC];
  logic [3:0] m_served;
  logic [3:0] m_drop;
  logic       m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] e_req, e_full, e_starve;
    for (int i = 0; i < NC; i++) begin
      e_req[i]    = (cnt[i] > 0);
      e_full[i]   = (cnt[i] == CMAX);
      e_starve[i] = (wt[i] == WMAX);
    end
    chk({tag, ".req"},    32'(bus.req_o),    32'(e_req));
    chk({tag, ".full"},   32'(bus.full_o),   32'(e_full));
    chk({tag, ".starve"}, 32'(bus.starve_o), 32'(e_starve));
    chk({tag, ".served"}, 32'(bus.served_o), 32'(m_served));
    chk({tag, ".drop"},   32'(bus.drop_o),   32'(m_drop));
    chk({tag, ".err"},    32'(bus.err_o),    32'(m_err));
  endtask

  // One clock: apply inputs, advance the model, check after the edge.
  task automatic step(input logic [3:0] push, input logic [3:0] gnt,
                      input logic rst_n, input string tag);
    logic [3:0] req_m, vg;
    int pc;
    @(negedge clk);
    bus.push_i = push;
    bus.gnt_i  = gnt;
    reset      = rst_n;
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) begin
        cnt[i] = 0;
        wt[i]  = 0;
      end
      m_served = '0;
      m_drop   = '0;
      m_err    = 1'b0;
    end else begin
      for (int i = 0; i < NC; i++) req_m[i] = (cnt[i] > 0);
      pc = $countones(gnt);
      vg = (pc == 1) ? (gnt & req_m) : 4'b0;
      if (pc > 1 || (pc == 1 && vg == 4'b0)) m_err = 1'b1;
      m_served = vg;
      m_drop   = '0;
      for (int i = 0; i < NC; i++) begin
        if (!req_m[i] || vg[i]) wt[i] = 0;
        else if (wt[i] < WMAX)  wt[i] = wt[i] + 1;
        if (push[i] && !vg[i]) begin
          if (cnt[i] == CMAX) m_drop[i] = 1'b1;
          else                cnt[i] = cnt[i] + 1;
        end else if (vg[i] && !push[i]) begin
          cnt[i] = cnt[i] - 1;
        end
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    reset      = 1'b0;
    bus.push_i = '0;
    bus.gnt_i  = '0;

    // Reset with pushes/grants present: all must be discarded.
    step(4'b1111, 4'b0001, 1'b0, "rst_a");
    step(4'b0000, 4'b0000, 1'b0, "rst_b");
    chk("rst.req", 32'(bus.req_o), 32'h0);
    chk("rst.err", 32'(bus.err_o), 32'h0);

    // Single request, then grant.
    step(4'b0001, 4'b0000, 1'b1, "r30_push");
    chk("r30.req_hi", 32'(bus.req_o), 32'h1);
    step(4'b0000, 4'b0001, 1'b1, "r30_gnt");
    chk("r30.served", 32'(bus.served_o), 32'h1);
    chk("r30.req_lo", 32'(bus.req_o), 32'h0);

    // Fill client 2 and overflow it.
    step(4'b0100, 4'b0000, 1'b1, "r31_p1");
    step(4'b0100, 4'b0000, 1'b1, "r31_p2");
    chk("r31.not_full", 32'(bus.full_o), 32'h0);
    step(4'b0100, 4'b0000, 1'b1, "r31_p3");
    chk("r31.full", 32'(bus.full_o), 32'h4);
    step(4'b0100, 4'b0000, 1'b1, "r31_p4");
    chk("r31.drop", 32'(bus.drop_o), 32'h4);
    step(4'b0000, 4'b0000, 1'b1, "r31_idle");
    chk("r31.still_full", 32'(bus.full_o), 32'h4);

    // Client 1 full, push and grant together.
    step(4'b0010, 4'b0000, 1'b1, "r32_p1");
    step(4'b0010, 4'b0000, 1'b1, "r32_p2");
    step(4'b0010, 4'b0000, 1'b1, "r32_p3");
    step(4'b0010, 4'b0010, 1'b1, "r32_pg");
    chk("r32.full", 32'(bus.full_o[1]), 32'h1);
    chk("r32.drop", 32'(bus.drop_o), 32'h0);
    chk("r32.served", 32'(bus.served_o), 32'h2);

    // Protocol errors.
    step(4'b0000, 4'b0000, 1'b0, "r33_rst");
    step(4'b0011, 4'b0000, 1'b1, "r33_push");
    chk("r33.req", 32'(bus.req_o), 32'h3);
    step(4'b0000, 4'b0011, 1'b1, "r33_multi");
    chk("r33.err", 32'(bus.err_o), 32'h1);
    chk("r33.served", 32'(bus.served_o), 32'h0);
    chk("r33.req_kept", 32'(bus.req_o), 32'h3);
    step(4'b0000, 4'b0100, 1'b1, "r33_idle_gnt");
    chk("r33.err_sticky", 32'(bus.err_o), 32'h1);

    // Starvation of client 3.
    step(4'b1000, 4'b0000, 1'b1, "r34_push");
    for (int k = 0; k < 6; k++) step(4'b0000, 4'b0000, 1'b1, "r34_wait");
    chk("r34.not_yet", 32'(bus.starve_o[3]), 32'h0);
    step(4'b0000, 4'b0000, 1'b1, "r34_wait7");
    chk("r34.starve", 32'(bus.starve_o[3]), 32'h1);
    step(4'b0000, 4'b1000, 1'b1, "r34_gnt");
    chk("r34.cleared", 32'(bus.starve_o[3]), 32'h0);

    // Mid-operation reset.
    step(4'b0110, 4'b0000, 1'b1, "r35_load");
    step(4'b0000, 4'b0000, 1'b0, "r35_rst");
    chk("r35.req", 32'(bus.req_o), 32'h0);
    chk("r35.starve", 32'(bus.starve_o), 32'h0);
    chk("r35.err", 32'(bus.err_o), 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      logic [3:0] p, g;
      int r;
      int cands[$];
      p = (n % 3 == 0) ? 4'($urandom) : (4'($urandom) & 4'($urandom));
      r = int'($urandom_range(0, 99));
      cands.delete();
      for (int i = 0; i < NC; i++) if (cnt[i] > 0) cands.push_back(i);
      if (r < 60 && cands.size() > 0)
        g = 4'b0001 << cands[$urandom_range(0, cands.size() - 1)];
      else if (r < 85) g = 4'b0000;
      else if (r < 93) g = 4'($urandom);
      else             g = 4'b0001 << $urandom_range(0, 3);
      step(p, g, ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
